johnson_decoder: RTL and testbench

Receiver/checker for an N-bit Johnson-counter code stream (sequence 0..0 -> 0..01 -> ... -> 1..1 -> 1..10 -> ... -> 10..0 -> 0..0, left-shift with inverted MSB fed into LSB).
Converts each sampled code to its binary state index 0..2N-1 and flags codes that are not legal Johnson codes.
Tracks sequence progression with a lock FSM and reports skips, wrap-around and a saturating error count.
Sits downstream of any Johnson-counter source, e.g. a ring sequencer or a clock-domain-crossed phase counter.

---
 rtl/johnson_pkg.sv | 19 +
 rtl/johnson_code_decode.sv | 34 +++
 rtl/johnson_decoder.sv | 130 +++++++++++++
 tb/tb_johnson_decoder.sv | 127 ++++++++++++
 4 files changed

// File: rtl/johnson_pkg.sv
// rtl/johnson_pkg.sv - shared types and constants for the Johnson code checker
package johnson_pkg;

    typedef enum logic [1:0] {
        UNLOCKED = 2'd0,
        ACQUIRE  = 2'd1,
        LOCKED   = 2'd2
    } lock_state_t;

    typedef enum logic [1:0] {
        SUCC = 2'd0,
        HOLD = 2'd1,
        JUMP = 2'd2,
        BAD  = 2'd3
    } step_class_t;

    localparam logic [7:0] ERR_MAX = 8'd255;

endpackage

// File: rtl/johnson_code_decode.sv
// rtl/johnson_code_decode.sv - combinational Johnson code legality check and index decode
module johnson_code_decode
    import johnson_pkg::*;
#(
    parameter  int N  = 4,
    localparam int CW = $clog2(2 * N)
) (
    input  logic [N-1:0]  jc,
    output logic          legal,
    output logic [CW-1:0] index
);

    logic [N-1:0] q_inc;
    logic [N-1:0] nq;
    logic [N-1:0] nq_inc;
    int           ones;

    // A legal code is a contiguous run of ones anchored at the LSB (MSB=0)
    // or a contiguous run of zeros anchored at the LSB (MSB=1).
    always_comb begin
        q_inc  = jc + N'(1);
        nq     = ~jc;
        nq_inc = nq + N'(1);
        ones   = $countones(jc);
        if (jc[N-1] == 1'b0) begin
            legal = ((jc & q_inc) == '0);
            index = CW'(ones);
        end else begin
            legal = ((nq & nq_inc) == '0);
            index = CW'(2 * N - ones);
        end
    end

endmodule

// File: rtl/johnson_decoder.sv
// rtl/johnson_decoder.sv - Johnson code stream decoder with lock tracking and error counting
module johnson_decoder
    import johnson_pkg::*;
#(
    parameter  int N        = 4,
    parameter  int LOCK_LEN = 2,
    localparam int CW       = $clog2(2 * N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          valid_in,
    input  logic [N-1:0]  jc_in,
    input  logic          err_clr,
    output logic          valid_out,
    output logic [CW-1:0] count,
    output logic          illegal,
    output logic          seq_err,
    output logic          wrap,
    output logic          locked,
    output logic [7:0]    err_cnt
);

    localparam logic [CW-1:0] LAST_IDX = CW'(2 * N - 1);

    lock_state_t   state, state_nxt;
    step_class_t   cls;
    logic [CW-1:0] ref_idx, ref_nxt;
    logic [CW-1:0] succ_idx;
    logic [CW-1:0] count_nxt;
    logic [3:0]    good, good_nxt;
    logic          dec_legal;
    logic [CW-1:0] dec_index;
    logic          illegal_nxt, seq_err_nxt, wrap_nxt;
    logic          err_event;

    johnson_code_decode #(.N(N)) u_decode (
        .jc    (jc_in),
        .legal (dec_legal),
        .index (dec_index)
    );

    // Successor wraps explicitly since 2N need not be a power of two.
    always_comb begin
        succ_idx = (ref_idx == LAST_IDX) ? '0 : ref_idx + CW'(1);
        if (!dec_legal)
            cls = BAD;
        else if (dec_index == succ_idx)
            cls = SUCC;
        else if (dec_index == ref_idx)
            cls = HOLD;
        else
            cls = JUMP;
    end

    always_comb begin
        state_nxt   = state;
        good_nxt    = good;
        ref_nxt     = ref_idx;
        count_nxt   = count;
        illegal_nxt = 1'b0;
        seq_err_nxt = 1'b0;
        wrap_nxt    = 1'b0;
        if (valid_in) begin
            if (cls == BAD) begin
                illegal_nxt = 1'b1;
                state_nxt   = UNLOCKED;
            end else begin
                ref_nxt   = dec_index;
                count_nxt = dec_index;
                case (state)
                    UNLOCKED: begin
                        state_nxt = ACQUIRE;
                        good_nxt  = '0;
                    end
                    ACQUIRE: begin
                        if (cls == SUCC) begin
                            good_nxt = good + 4'd1;
                            if (good + 4'd1 == 4'(LOCK_LEN))
                                state_nxt = LOCKED;
                        end else if (cls == JUMP) begin
                            good_nxt = '0;
                        end
                    end
                    LOCKED: begin
                        if (cls == SUCC) begin
                            wrap_nxt = (ref_idx == LAST_IDX) && (dec_index == '0);
                        end else if (cls == JUMP) begin
                            state_nxt   = ACQUIRE;
                            good_nxt    = '0;
                            seq_err_nxt = 1'b1;
                        end
                    end
                    default: state_nxt = UNLOCKED;
                endcase
            end
        end
    end

    assign err_event = illegal_nxt | seq_err_nxt;
    assign locked    = (state == LOCKED);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= UNLOCKED;
            good      <= '0;
            ref_idx   <= '0;
            count     <= '0;
            valid_out <= 1'b0;
            illegal   <= 1'b0;
            seq_err   <= 1'b0;
            wrap      <= 1'b0;
            err_cnt   <= '0;
        end else begin
            state     <= state_nxt;
            good      <= good_nxt;
            ref_idx   <= ref_nxt;
            count     <= count_nxt;
            valid_out <= valid_in;
            illegal   <= illegal_nxt;
            seq_err   <= seq_err_nxt;
            wrap      <= wrap_nxt;
            // A clear coinciding with an event restarts the count at one.
            if (err_clr)
                err_cnt <= err_event ? 8'd1 : 8'd0;
            else if (err_event && err_cnt != ERR_MAX)
                err_cnt <= err_cnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_johnson_decoder.sv
// tb/tb_johnson_decoder.sv - directed self-checking bench for johnson_decoder
module tb_johnson_decoder;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       valid_in = 1'b0;
    logic [3:0] jc_in = 4'b0000;
    logic       err_clr = 1'b0;
    logic       valid_out;
    logic [2:0] count;
    logic       illegal, seq_err, wrap, locked;
    logic [7:0] err_cnt;

    int checks   = 0;
    int failures = 0;

    johnson_decoder #(.N(4), .LOCK_LEN(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .valid_in  (valid_in),
        .jc_in     (jc_in),
        .err_clr   (err_clr),
        .valid_out (valid_out),
        .count     (count),
        .illegal   (illegal),
        .seq_err   (seq_err),
        .wrap      (wrap),
        .locked    (locked),
        .err_cnt   (err_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [3:0] code, input logic clr);
        valid_in = v;
        jc_in    = code;
        err_clr  = clr;
        @(posedge clk);
        #1;
        valid_in = 1'b0;
        err_clr  = 1'b0;
    endtask

    task automatic expect_out(input string tag, input logic vo, input logic [2:0] cnt,
                              input logic ill, input logic se, input logic wr,
                              input logic lk, input logic [7:0] ec);
        chk({tag, ".valid_out"}, 32'(valid_out), 32'(vo));
        chk({tag, ".count"},     32'(count),     32'(cnt));
        chk({tag, ".illegal"},   32'(illegal),   32'(ill));
        chk({tag, ".seq_err"},   32'(seq_err),   32'(se));
        chk({tag, ".wrap"},      32'(wrap),      32'(wr));
        chk({tag, ".locked"},    32'(locked),    32'(lk));
        chk({tag, ".err_cnt"},   32'(err_cnt),   32'(ec));
    endtask

    initial begin
        #2;
        expect_out("reset", 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b0;

        // acquisition from reset
        drive(1, 4'b0000, 0); expect_out("s1_0000", 1, 0, 0, 0, 0, 0, 0);
        drive(1, 4'b0001, 0); expect_out("s1_0001", 1, 1, 0, 0, 0, 0, 0);
        drive(1, 4'b0011, 0); expect_out("s1_0011", 1, 2, 0, 0, 0, 1, 0);

        // illegal code drops lock, then re-acquire
        drive(1, 4'b0101, 0); expect_out("s2_0101", 1, 2, 1, 0, 0, 0, 1);
        drive(1, 4'b0111, 0); expect_out("s2_0111", 1, 3, 0, 0, 0, 0, 1);
        drive(1, 4'b1111, 0); expect_out("s2_1111", 1, 4, 0, 0, 0, 0, 1);
        drive(1, 4'b1110, 0); expect_out("s2_1110", 1, 5, 0, 0, 0, 1, 1);

        // wrap-around while locked
        drive(1, 4'b1100, 0); expect_out("s3_1100", 1, 6, 0, 0, 0, 1, 1);
        drive(1, 4'b1000, 0); expect_out("s3_1000", 1, 7, 0, 0, 0, 1, 1);
        drive(1, 4'b0000, 0); expect_out("s3_wrap", 1, 0, 0, 0, 1, 1, 1);
        drive(1, 4'b0001, 0); expect_out("s3_0001", 1, 1, 0, 0, 0, 1, 1);

        // jump while locked
        drive(1, 4'b0011, 0); expect_out("s4_0011", 1, 2, 0, 0, 0, 1, 1);
        drive(1, 4'b1111, 0); expect_out("s4_jump", 1, 4, 0, 1, 0, 0, 2);
        drive(1, 4'b1110, 0); expect_out("s4_1110", 1, 5, 0, 0, 0, 0, 2);
        drive(1, 4'b1100, 0); expect_out("s4_1100", 1, 6, 0, 0, 0, 1, 2);

        // walk to 0111 locked, then holds with idle gaps
        drive(1, 4'b1000, 0); expect_out("s5_1000", 1, 7, 0, 0, 0, 1, 2);
        drive(1, 4'b0000, 0); expect_out("s5_0000", 1, 0, 0, 0, 1, 1, 2);
        drive(1, 4'b0001, 0); expect_out("s5_0001", 1, 1, 0, 0, 0, 1, 2);
        drive(1, 4'b0011, 0); expect_out("s5_0011", 1, 2, 0, 0, 0, 1, 2);
        drive(1, 4'b0111, 0); expect_out("s5_0111", 1, 3, 0, 0, 0, 1, 2);
        for (int i = 0; i < 3; i++) begin
            drive(0, 4'b1010, 0); expect_out("s5_gap",  0, 3, 0, 0, 0, 1, 2);
            drive(1, 4'b0111, 0); expect_out("s5_hold", 1, 3, 0, 0, 0, 1, 2);
        end

        // error counter saturation and clear
        for (int i = 0; i < 260; i++)
            drive(1, 4'b1010, 0);
        expect_out("s6_sat", 1, 3, 1, 0, 0, 0, 255);
        drive(1, 4'b1011, 0); expect_out("s6_sat2", 1, 3, 1, 0, 0, 0, 255);
        drive(1, 4'b1010, 1); expect_out("s6_clr", 1, 3, 1, 0, 0, 0, 1);
        drive(1, 4'b0000, 0); expect_out("s6_0000", 1, 0, 0, 0, 0, 0, 1);
        drive(1, 4'b0001, 0); expect_out("s6_0001", 1, 1, 0, 0, 0, 0, 1);
        drive(1, 4'b0011, 0); expect_out("s6_0011", 1, 2, 0, 0, 0, 1, 1);

        // asynchronous reset mid-cycle
        #3;
        rst = 1'b1;
        #1;
        expect_out("s6_rst", 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b0;
        drive(1, 4'b0000, 0); expect_out("s6_after", 1, 0, 0, 0, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
